// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling, LSB-first data, one stop bit.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int CLOCKS_PER_PULSE = 16,
  parameter int DATA_WIDTH       = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  rx_busy
);

  localparam int CNT_W = $clog2(CLOCKS_PER_PULSE);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

`ifdef UART_RX_PARITY_EN
  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  logic                  rx_meta_q, rx_s_q, rx_d_q;
  logic                  start_det_s;
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  par_bad_s;
`ifdef UART_RX_PARITY_EN
  logic                  par_bad_q, par_bad_d;
  logic                  perr_q, perr_d;
  assign par_bad_s  = par_bad_q;
  assign parity_err = perr_q;
`else
  assign par_bad_s  = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign start_det_s = rx_d_q & ~rx_s_q;

  // Line synchronizer plus one-cycle delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
    end
  end

  // Receiver state, counters, shift register and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  // Next-state logic: sample at half a bit for START, full bit periods afterwards
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_det_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          idx_d = '0;
          // A line that is high again at mid-start-bit was only a glitch
          if (!rx_s_q) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          par_bad_d = rx_s_q ^ even_parity(shift_q);
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          // Leaving at mid-stop-bit lets a gapless next start bit be seen
          state_d = IDLE;
          ferr_d  = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
          perr_d  = par_bad_q;
`endif
          if (rx_s_q && !par_bad_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            data_d  = data_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign rx_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks/bit, 8 data bits; randomized frames
// checked against a frame-level model. Parity scenarios run when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int CPP = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid, frame_err, parity_err, rx_busy;

  int         n_vec = 0;
  int         n_err = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         overlap_cnt = 0;
  int         exp_ferr = 0;
  int         exp_perr = 0;
  logic [7:0] got_q[$];
  logic       busy_mid;
  logic       par_bit = 1'b0;
  logic [7:0] last_good = 8'h00;

  uart_rx #(.CLOCKS_PER_PULSE(CPP), .DATA_WIDTH(8)) dut (
    .clk(clk), .rstn(rstn), .rx(rx),
    .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err),
    .parity_err(parity_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  // Record output pulses away from the active edge
  always @(negedge clk) begin
    if (rstn) begin
      if (data_valid) got_q.push_back(data_out);
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      if (parity_err) perr_cnt <= perr_cnt + 1;
      if (data_valid && (frame_err || parity_err)) overlap_cnt <= overlap_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serialize one frame; the line is left at the stop-bit level
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    rx = 1'b0;
    repeat (CPP) tick();
    busy_mid = rx_busy;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPP) tick();
    end
`ifdef UART_RX_PARITY_EN
    rx = par_bit;
    repeat (CPP) tick();
`endif
    rx = stop_b;
    repeat (CPP) tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    rx   = 1'b1;
    repeat (3) tick();
    n_vec++;
    if ({data_out, data_valid, frame_err, parity_err, rx_busy} !== 12'h000) begin
      $display("FAIL reset_outputs: got %h required 000",
               {data_out, data_valid, frame_err, parity_err, rx_busy});
      n_err++;
    end
    rstn = 1'b1;
    repeat (4) tick();
    n_vec++;
    if (rx_busy !== 1'b0) begin
      $display("FAIL idle_after_reset: rx_busy got %b required 0", rx_busy);
      n_err++;
    end
  endtask

  task automatic test_basic();
`ifdef UART_RX_PARITY_EN
    par_bit = ^8'hA5;
`endif
    send_frame(8'hA5, 1'b1);
    last_good = 8'hA5;
    n_vec++;
    if (busy_mid !== 1'b1) begin
      $display("FAIL basic_busy_mid: got %b required 1", busy_mid);
      n_err++;
    end
    n_vec++;
    if (got_q.size() !== 1) begin
      $display("FAIL basic_valid_count: got %0d required 1", got_q.size());
      n_err++;
    end else begin
      n_vec++;
      if (got_q.pop_front() !== 8'hA5) begin
        $display("FAIL basic_word: required a5");
        n_err++;
      end
    end
    n_vec++;
    if (data_out !== 8'hA5 || rx_busy !== 1'b0 || ferr_cnt !== exp_ferr) begin
      $display("FAIL basic_state: data_out %h busy %b ferr %0d required a5 0 %0d",
               data_out, rx_busy, ferr_cnt, exp_ferr);
      n_err++;
    end
    repeat (4) tick();
  endtask

  task automatic test_glitch();
    int waited;
    rx = 1'b0;
    repeat (5) tick();
    n_vec++;
    if (rx_busy !== 1'b1) begin
      $display("FAIL glitch_busy_rise: got %b required 1", rx_busy);
      n_err++;
    end
    rx = 1'b1;
    waited = 5;
    while (rx_busy === 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    n_vec++;
    if (waited > 11) begin
      $display("FAIL glitch_abort_time: busy low after %0d clocks required <= 11", waited);
      n_err++;
    end
    repeat (CPP) tick();
    n_vec++;
    if (got_q.size() !== 0 || ferr_cnt !== exp_ferr || rx_busy !== 1'b0) begin
      $display("FAIL glitch_no_pulse: words %0d ferr %0d busy %b required 0 %0d 0",
               got_q.size(), ferr_cnt, rx_busy, exp_ferr);
      n_err++;
    end
  endtask

  task automatic test_frame_err();
    logic [7:0] d;
`ifdef UART_RX_PARITY_EN
    par_bit = ^8'h3C;
`endif
    send_frame(8'h3C, 1'b0);
    exp_ferr++;
    repeat (40 - CPP) tick();
    n_vec++;
    if (ferr_cnt !== exp_ferr || got_q.size() !== 0 || data_out !== last_good) begin
      $display("FAIL frame_err: ferr %0d words %0d data_out %h required %0d 0 %h",
               ferr_cnt, got_q.size(), data_out, exp_ferr, last_good);
      n_err++;
    end
    n_vec++;
    if (rx_busy !== 1'b0) begin
      $display("FAIL low_line_restart: rx_busy got %b required 0", rx_busy);
      n_err++;
    end
    rx = 1'b1;
    repeat (8) tick();
    d = 8'($urandom_range(0, 255));
`ifdef UART_RX_PARITY_EN
    par_bit = ^d;
`endif
    send_frame(d, 1'b1);
    last_good = d;
    n_vec++;
    if (got_q.size() !== 1 || data_out !== d) begin
      $display("FAIL recover_after_ferr: words %0d data_out %h required 1 %h",
               got_q.size(), data_out, d);
      n_err++;
    end
    got_q.delete();
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
`ifdef UART_RX_PARITY_EN
    par_bit = 1'b0;
`endif
    send_frame(8'h00, 1'b1);
`ifdef UART_RX_PARITY_EN
    par_bit = 1'b0;
`endif
    send_frame(8'hFF, 1'b1);
    last_good = 8'hFF;
    n_vec++;
    if (got_q.size() !== 2) begin
      $display("FAIL b2b_count: got %0d required 2", got_q.size());
      n_err++;
      got_q.delete();
    end else begin
      n_vec++;
      if (got_q[0] !== 8'h00 || got_q[1] !== 8'hFF) begin
        $display("FAIL b2b_words: got %h %h required 00 ff", got_q[0], got_q[1]);
        n_err++;
      end
      got_q.delete();
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    rx = 1'b0;
    repeat (CPP) tick();
    for (int i = 0; i < 3; i++) begin
      rx = 1'(i & 1);
      repeat (CPP) tick();
    end
    rx = 1'b1;
    repeat (CPP / 2) tick();
    rstn = 1'b0;
    #1;
    n_vec++;
    if ({data_out, data_valid, frame_err, parity_err, rx_busy} !== 12'h000) begin
      $display("FAIL reset_mid_outputs: got %h required 000",
               {data_out, data_valid, frame_err, parity_err, rx_busy});
      n_err++;
    end
    repeat (2) tick();
    rstn = 1'b1;
    last_good = 8'h00;
    repeat (CPP) tick();
    n_vec++;
    if (got_q.size() !== 0 || rx_busy !== 1'b0) begin
      $display("FAIL reset_mid_discard: words %0d busy %b required 0 0", got_q.size(), rx_busy);
      n_err++;
    end
`ifdef UART_RX_PARITY_EN
    par_bit = ^8'h5A;
`endif
    send_frame(8'h5A, 1'b1);
    last_good = 8'h5A;
    n_vec++;
    if (got_q.size() !== 1 || data_out !== 8'h5A) begin
      $display("FAIL reset_mid_next: words %0d data_out %h required 1 5a", got_q.size(), data_out);
      n_err++;
    end
    got_q.delete();
    repeat (4) tick();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    par_bit = 1'b1;
    send_frame(8'h07, 1'b1);
    last_good = 8'h07;
    n_vec++;
    if (got_q.size() !== 1 || data_out !== 8'h07 || perr_cnt !== exp_perr) begin
      $display("FAIL parity_good: words %0d data_out %h perr %0d required 1 07 %0d",
               got_q.size(), data_out, perr_cnt, exp_perr);
      n_err++;
    end
    got_q.delete();
    par_bit = 1'b0;
    send_frame(8'h07, 1'b1);
    exp_perr++;
    n_vec++;
    if (got_q.size() !== 0 || perr_cnt !== exp_perr || data_out !== 8'h07) begin
      $display("FAIL parity_bad: words %0d perr %0d data_out %h required 0 %0d 07",
               got_q.size(), perr_cnt, data_out, exp_perr);
      n_err++;
    end
    repeat (4) tick();
  endtask
`endif

  // Random frames, gaps and stop levels against a frame-level expectation
  task automatic test_random();
    logic [7:0] d;
    logic       stop_b;
    logic       good;
    for (int f = 0; f < 24; f++) begin
      d      = 8'($urandom_range(0, 255));
      stop_b = ($urandom_range(0, 4) != 0);
      good   = stop_b;
`ifdef UART_RX_PARITY_EN
      par_bit = ($urandom_range(0, 3) != 0) ? ^d : ~(^d);
      if (par_bit != ^d) begin
        good = 1'b0;
        exp_perr++;
      end
`endif
      send_frame(d, stop_b);
      if (!stop_b) exp_ferr++;
      if (good) last_good = d;
      n_vec++;
      if (good) begin
        if (got_q.size() !== 1 || data_out !== d) begin
          $display("FAIL random_frame%0d: words %0d data_out %h required 1 %h",
                   f, got_q.size(), data_out, d);
          n_err++;
        end
      end else begin
        if (got_q.size() !== 0 || data_out !== last_good) begin
          $display("FAIL random_reject%0d: words %0d data_out %h required 0 %h",
                   f, got_q.size(), data_out, last_good);
          n_err++;
        end
      end
      got_q.delete();
      rx = 1'b1;
      if (stop_b) begin
        repeat ($urandom_range(0, 20)) tick();
      end else begin
        repeat ($urandom_range(4, 20)) tick();
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    rx   = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    repeat (4) tick();
    n_vec++;
    if (ferr_cnt !== exp_ferr || perr_cnt !== exp_perr) begin
      $display("FAIL error_totals: ferr %0d perr %0d required %0d %0d",
               ferr_cnt, perr_cnt, exp_ferr, exp_perr);
      n_err++;
    end
    n_vec++;
    if (overlap_cnt !== 0) begin
      $display("FAIL valid_with_error: got %0d required 0", overlap_cnt);
      n_err++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCKS_PER_PULSE, default 16, meaning system clocks per serial bit period; even, >= 4.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx  input  1  serial line, idle high, asynchronous to clk.
REQ-006 SHALL have port data_out  output  DATA_WIDTH  last correctly received word.
REQ-007 SHALL have port data_valid  output  1  one-cycle pulse; data_out updated this cycle.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-009 SHALL have port parity_err  output  1  one-cycle pulse; parity mismatch (see Configuration).
REQ-010 SHALL have port rx_busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer (rx_s) and hold a 1-cycle delayed copy (rx_d); start detect = rx_d==1 and rx_s==0.
REQ-012 SHALL implement states IDLE, START, DATA, STOP (and PARITY when enabled), using a bit-period counter of width $clog2(CLOCKS_PER_PULSE) and a bit index counter.
REQ-013 IDLE: on start detect -> START, counter cleared; a continuously low line SHALL NOT trigger a new start.
REQ-014 START: at counter == CLOCKS_PER_PULSE/2-1, sample rx_s; if 0 -> DATA, counters cleared; if 1 -> IDLE with no output pulse (glitch rejection).
REQ-015 DATA: at counter == CLOCKS_PER_PULSE-1, sample rx_s into bit [index], LSB first; after bit DATA_WIDTH-1 -> STOP (or PARITY); counter wraps to 0 on every sample.
REQ-016 Bit k SHALL be sampled (k+1)*CLOCKS_PER_PULSE + CLOCKS_PER_PULSE/2 - 1 clocks after start detect, i.e. mid-bit.
REQ-017 STOP: at counter == CLOCKS_PER_PULSE-1, sample rx_s; if 1 and no parity error -> data_out loaded from shift register and data_valid pulsed on the next cycle; if 0 -> frame_err pulsed, data_out unchanged; both cases -> IDLE.
REQ-018 The return to IDLE at mid-stop-bit SHALL allow a following start bit with zero idle gap to be detected.
REQ-019 frame_err and parity_err MAY assert together; data_valid SHALL never assert with either.
REQ-020 data_out SHALL hold its value between frames; the partial shift register SHALL NOT be visible on data_out.

Reset
REQ-021 rstn low SHALL immediately force state IDLE, counters 0, shift register 0, data_out 0, data_valid/frame_err/parity_err/rx_busy 0, and both synchronizer flops and rx_d to 1.
REQ-022 Reset mid-frame SHALL discard the partial frame; the next frame SHALL be accepted only after a new start detect.

Configuration
REQ-023 Macro UART_RX_PARITY_EN defined: a PARITY state between DATA and STOP samples one even-parity bit at the same mid-bit timing; mismatch with XOR of data bits -> parity_err pulsed at the STOP sample, data_valid suppressed, data_out unchanged.
REQ-024 Macro UART_RX_PARITY_EN undefined: no PARITY state, frame is start + DATA_WIDTH + stop, parity_err tied 0, port retained.

Verification (CLOCKS_PER_PULSE=16, DATA_WIDTH=8 unless stated)
REQ-025 Frame 0xA5 at 16 clocks/bit, stop high -> data_out=0xA5, one data_valid pulse, frame_err=0, rx_busy falls after stop mid-sample.
REQ-026 rx low for 5 clocks then high -> START aborts at half-bit, no pulses, rx_busy low within 11 clocks of the low edge.
REQ-027 After 0xA5, frame 0x3C with stop bit low held low 40 clocks -> frame_err pulse, data_out stays 0xA5, no new frame until rx returns high and falls again.
REQ-028 Back-to-back frames 0x00 then 0xFF, no idle gap -> two data_valid pulses, data_out 0x00 then 0xFF.
REQ-029 rstn pulsed low during data bit 3 -> all outputs 0 at once; subsequent frame 0x5A -> data_out=0x5A, one data_valid.
REQ-030 UART_RX_PARITY_EN defined: 0x07 with parity bit 1 -> data_valid, data_out=0x07; with parity bit 0 -> parity_err pulse, no data_valid.
